// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding word read to imem, a small FIFO of
// fetched words, and a valid/ready head toward decode. Redirects flush and refetch.
module ifu #(
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
    parameter int               DEPTH        = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_re,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [29:0]     instr_out,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_illegal
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t          state_reg, state_next;
    logic            imem_re_next;
    logic [XLEN-1:0] imem_addr_next;
    logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
    logic [PW:0]     count_reg;
    logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic            push, pop;

    logic [29:0]     word_mem [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic            ill_mem  [DEPTH];
    logic [DEPTH-1:0] entry_we;

    // Low address bits of a redirect target are ignored by construction.
    logic unused_redirect_bits;
    assign unused_redirect_bits = ^redirect_pc[1:0];

    assign instr_valid   = (count_reg != '0);
    assign pop           = instr_valid && instr_ready;
    assign instr_out     = word_mem[rd_ptr_reg];
    assign instr_pc      = pc_mem[rd_ptr_reg];
    assign instr_illegal = ill_mem[rd_ptr_reg];

    always_comb begin
        state_next     = state_reg;
        imem_re_next   = imem_re;
        imem_addr_next = imem_addr;
        fetch_pc_next  = fetch_pc_reg;
        push           = 1'b0;
        case (state_reg)
            IDLE: begin
                // Only issue when the response is guaranteed a free slot.
                if (!redirect && (count_reg < DEPTH_C)) begin
                    state_next     = WAIT;
                    imem_re_next   = 1'b1;
                    imem_addr_next = fetch_pc_reg;
                end
            end
            WAIT: begin
                if (imem_ack) begin
                    state_next   = IDLE;
                    imem_re_next = 1'b0;
                    if (!redirect) begin
                        push          = 1'b1;
                        fetch_pc_next = fetch_pc_reg + XLEN'(4);
                    end
                end else if (redirect) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    state_next   = IDLE;
                    imem_re_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
        if (redirect) begin
            fetch_pc_next = {redirect_pc[XLEN-1:2], 2'b00};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            imem_re      <= 1'b0;
            imem_addr    <= RESET_VECTOR;
            fetch_pc_reg <= RESET_VECTOR;
        end else begin
            state_reg    <= state_next;
            imem_re      <= imem_re_next;
            imem_addr    <= imem_addr_next;
            fetch_pc_reg <= fetch_pc_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (redirect) begin
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (PW+1)'(1);
                2'b01:   count_reg <= count_reg - (PW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
        assign entry_we[gi] = push && (wr_ptr_reg == PW'(gi));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                word_mem[i] <= '0;
                pc_mem[i]   <= '0;
                ill_mem[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entry_we[i]) begin
                    word_mem[i] <= imem_rdata[31:2];
                    pc_mem[i]   <= imem_addr;
                    ill_mem[i]  <= (imem_rdata[1:0] != 2'b11);
                end
            end
        end
    end

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: reset, streaming, backpressure, redirects,
// illegal encodings, PC wrap and asynchronous mid-operation reset.
module tb_ifu;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_re;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [29:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_illegal;

    int nerr = 0;
    int nchk = 0;

    logic auto_en = 1'b0, auto_ack = 1'b0, man_ack = 1'b0;

    always #5 clk = ~clk;

    ifu #(.XLEN(32), .RESET_VECTOR(32'h100), .DEPTH(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_re(imem_re), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_out(instr_out),
        .instr_pc(instr_pc), .instr_illegal(instr_illegal)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h300) return 32'h0000_0001;
        return {a[29:0], 2'b11};
    endfunction

    assign imem_rdata = mem_word(imem_addr);
    assign imem_ack   = auto_ack | man_ack;

    // Zero-wait memory: acks in the cycle following the request edge.
    always begin
        @(posedge clk);
        #2;
        auto_ack = auto_en && imem_re && !auto_ack;
    end

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; auto_en = 1'b0; man_ack = 1'b0;
        redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        nchk++; if (imem_re !== 1'b0) begin nerr++; $display("FAIL reset_re got=%b exp=0", imem_re); end
        nchk++; if (imem_addr !== 32'h100) begin nerr++; $display("FAIL reset_addr got=%h exp=00000100", imem_addr); end
        nchk++; if (instr_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
        nchk++; if (instr_out !== 30'h0) begin nerr++; $display("FAIL reset_out got=%h exp=0", instr_out); end
        nchk++; if (instr_pc !== 32'h0) begin nerr++; $display("FAIL reset_pc got=%h exp=0", instr_pc); end
        nchk++; if (instr_illegal !== 1'b0) begin nerr++; $display("FAIL reset_illegal got=%b exp=0", instr_illegal); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [3];
        logic [31:0] w;
        int found = 0;
        int last = 0;
        exp_pc[0] = 32'h100; exp_pc[1] = 32'h104; exp_pc[2] = 32'h108;
        do_reset();
        instr_ready = 1'b1; auto_en = 1'b1;
        @(negedge clk);
        nchk++; if (imem_re !== 1'b1 || imem_addr !== 32'h100) begin
            nerr++; $display("FAIL first_req got re=%b addr=%h exp re=1 addr=00000100", imem_re, imem_addr);
        end
        for (int c = 0; c < 30 && found < 3; c++) begin
            if (instr_valid === 1'b1) begin
                w = mem_word(exp_pc[found]);
                $display("seq head pc=%h out=%h ill=%b cycle=%0d", instr_pc, instr_out, instr_illegal, c);
                nchk++; if (instr_pc !== exp_pc[found]) begin nerr++; $display("FAIL seq_pc got=%h exp=%h", instr_pc, exp_pc[found]); end
                nchk++; if (instr_out !== w[31:2]) begin nerr++; $display("FAIL seq_out got=%h exp=%h", instr_out, w[31:2]); end
                nchk++; if (instr_illegal !== 1'b0) begin nerr++; $display("FAIL seq_illegal got=%b exp=0", instr_illegal); end
                if (found > 0) begin
                    nchk++; if (c - last != 2) begin nerr++; $display("FAIL seq_spacing got=%0d exp=2", c - last); end
                end
                last = c;
                found++;
            end
            @(negedge clk);
        end
        nchk++; if (found != 3) begin nerr++; $display("FAIL seq_timeout got=%0d heads exp=3", found); end
        instr_ready = 1'b0; auto_en = 1'b0;
    endtask

    task automatic test_backpressure();
        int acks = 0;
        do_reset();
        auto_en = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (imem_ack === 1'b1) acks++;
        end
        $display("bp requests acked=%0d re=%b", acks, imem_re);
        nchk++; if (acks != 2) begin nerr++; $display("FAIL bp_requests got=%0d exp=2", acks); end
        nchk++; if (imem_re !== 1'b0) begin nerr++; $display("FAIL bp_re_idle got=%b exp=0", imem_re); end
        nchk++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin
            nerr++; $display("FAIL bp_head0 got v=%b pc=%h exp v=1 pc=00000100", instr_valid, instr_pc);
        end
        instr_ready = 1'b1;
        @(negedge clk);
        nchk++; if (instr_valid !== 1'b1 || instr_pc !== 32'h104) begin
            nerr++; $display("FAIL bp_head1 got v=%b pc=%h exp v=1 pc=00000104", instr_valid, instr_pc);
        end
        @(negedge clk);
        nchk++; if (instr_valid !== 1'b0) begin nerr++; $display("FAIL bp_drained got=%b exp=0", instr_valid); end
        nchk++; if (imem_re !== 1'b1 || imem_addr !== 32'h108) begin
            nerr++; $display("FAIL bp_resume got re=%b addr=%h exp re=1 addr=00000108", imem_re, imem_addr);
        end
        instr_ready = 1'b0; auto_en = 1'b0;
    endtask

    task automatic test_redirect_wait();
        logic [31:0] w;
        bit ok = 0;
        bit saw_108 = 0;
        do_reset();
        instr_ready = 1'b1; auto_en = 1'b1;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (imem_re === 1'b1 && imem_addr === 32'h104) ok = 1;
        end
        auto_en = 1'b0;
        nchk++; if (!ok) begin nerr++; $display("FAIL rw_reach104 got=none exp=request 00000104"); end
        @(negedge clk);
        @(negedge clk);
        nchk++; if (imem_re !== 1'b1 || imem_addr !== 32'h108) begin
            nerr++; $display("FAIL rw_wait108 got re=%b addr=%h exp re=1 addr=00000108", imem_re, imem_addr);
        end
        redirect = 1'b1; redirect_pc = 32'h203;
        @(negedge clk);
        redirect = 1'b0;
        nchk++; if (instr_valid !== 1'b0) begin nerr++; $display("FAIL rw_flush got=%b exp=0", instr_valid); end
        nchk++; if (imem_re !== 1'b1 || imem_addr !== 32'h108) begin
            nerr++; $display("FAIL rw_hold got re=%b addr=%h exp re=1 addr=00000108", imem_re, imem_addr);
        end
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        if (instr_valid === 1'b1 && instr_pc === 32'h108) saw_108 = 1;
        nchk++; if (imem_re !== 1'b0) begin nerr++; $display("FAIL rw_drop_re got=%b exp=0", imem_re); end
        @(negedge clk);
        nchk++; if (imem_re !== 1'b1 || imem_addr !== 32'h200) begin
            nerr++; $display("FAIL rw_target got re=%b addr=%h exp re=1 addr=00000200", imem_re, imem_addr);
        end
        auto_en = 1'b1;
        ok = 0;
        for (int c = 0; c < 10 && !ok; c++) begin
            if (instr_valid === 1'b1) begin
                ok = 1;
                if (instr_pc === 32'h108) saw_108 = 1;
                w = mem_word(32'h200);
                $display("redirect head pc=%h out=%h", instr_pc, instr_out);
                nchk++; if (instr_pc !== 32'h200) begin nerr++; $display("FAIL rw_first_pc got=%h exp=00000200", instr_pc); end
                nchk++; if (instr_out !== w[31:2]) begin nerr++; $display("FAIL rw_first_out got=%h exp=%h", instr_out, w[31:2]); end
            end else begin
                @(negedge clk);
            end
        end
        nchk++; if (!ok) begin nerr++; $display("FAIL rw_timeout got=no head exp=head 00000200"); end
        nchk++; if (saw_108) begin nerr++; $display("FAIL rw_stale got=00000108 presented exp=never"); end
        instr_ready = 1'b0; auto_en = 1'b0;
    endtask

    task automatic test_redirect_ack_pop();
        do_reset();
        @(negedge clk);
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        @(negedge clk);
        nchk++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || imem_re !== 1'b1 || imem_addr !== 32'h104) begin
            nerr++; $display("FAIL rap_setup got v=%b pc=%h re=%b addr=%h exp v=1 pc=00000100 re=1 addr=00000104",
                             instr_valid, instr_pc, imem_re, imem_addr);
        end
        man_ack = 1'b1; instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h400;
        @(negedge clk);
        man_ack = 1'b0; instr_ready = 1'b0; redirect = 1'b0;
        $display("collision valid=%b re=%b", instr_valid, imem_re);
        nchk++; if (instr_valid !== 1'b0) begin nerr++; $display("FAIL rap_empty got=%b exp=0", instr_valid); end
        nchk++; if (imem_re !== 1'b0) begin nerr++; $display("FAIL rap_re got=%b exp=0", imem_re); end
        @(negedge clk);
        nchk++; if (instr_valid !== 1'b0) begin nerr++; $display("FAIL rap_nopush got=%b exp=0", instr_valid); end
        nchk++; if (imem_re !== 1'b1 || imem_addr !== 32'h400) begin
            nerr++; $display("FAIL rap_target got re=%b addr=%h exp re=1 addr=00000400", imem_re, imem_addr);
        end
    endtask

    task automatic test_illegal();
        bit ok = 0;
        do_reset();
        redirect = 1'b1; redirect_pc = 32'h300; auto_en = 1'b1;
        @(negedge clk);
        redirect = 1'b0;
        for (int c = 0; c < 10 && !ok; c++) begin
            if (instr_valid === 1'b1) ok = 1;
            else @(negedge clk);
        end
        $display("illegal head pc=%h out=%h ill=%b", instr_pc, instr_out, instr_illegal);
        nchk++; if (!ok) begin nerr++; $display("FAIL ill_timeout got=no head exp=head 00000300"); end
        nchk++; if (instr_illegal !== 1'b1) begin nerr++; $display("FAIL ill_flag got=%b exp=1", instr_illegal); end
        nchk++; if (instr_out !== 30'h0) begin nerr++; $display("FAIL ill_out got=%h exp=0000000", instr_out); end
        nchk++; if (instr_pc !== 32'h300) begin nerr++; $display("FAIL ill_pc got=%h exp=00000300", instr_pc); end
        auto_en = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] w;
        bit ok = 0;
        do_reset();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE; auto_en = 1'b1; instr_ready = 1'b1;
        @(negedge clk);
        redirect = 1'b0;
        for (int c = 0; c < 10 && !ok; c++) begin
            if (instr_valid === 1'b1) ok = 1;
            else @(negedge clk);
        end
        w = mem_word(32'hFFFF_FFFC);
        nchk++; if (!ok || instr_pc !== 32'hFFFF_FFFC || instr_out !== w[31:2]) begin
            nerr++; $display("FAIL wrap_head got v=%b pc=%h out=%h exp v=1 pc=fffffffc out=%h", ok, instr_pc, instr_out, w[31:2]);
        end
        ok = 0;
        for (int c = 0; c < 10 && !ok; c++) begin
            @(negedge clk);
            if (imem_re === 1'b1) ok = 1;
        end
        $display("wrap next req re=%b addr=%h", imem_re, imem_addr);
        nchk++; if (!ok || imem_addr !== 32'h0) begin
            nerr++; $display("FAIL wrap_addr got re=%b addr=%h exp re=1 addr=00000000", ok, imem_addr);
        end
        instr_ready = 1'b0; auto_en = 1'b0;
    endtask

    task automatic test_mid_reset();
        bit ok = 0;
        do_reset();
        auto_en = 1'b1;
        for (int c = 0; c < 10 && !ok; c++) begin
            @(negedge clk);
            if (instr_valid === 1'b1 && imem_re === 1'b1) ok = 1;
        end
        nchk++; if (!ok) begin nerr++; $display("FAIL mr_setup got=no busy state exp=valid head and request"); end
        reset_n = 1'b0;
        #1;
        nchk++; if (imem_re !== 1'b0 || instr_valid !== 1'b0) begin
            nerr++; $display("FAIL mr_async got re=%b v=%b exp re=0 v=0", imem_re, instr_valid);
        end
        nchk++; if (imem_addr !== 32'h100 || instr_pc !== 32'h0) begin
            nerr++; $display("FAIL mr_values got addr=%h pc=%h exp addr=00000100 pc=0", imem_addr, instr_pc);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        nchk++; if (imem_re !== 1'b1 || imem_addr !== 32'h100) begin
            nerr++; $display("FAIL mr_restart got re=%b addr=%h exp re=1 addr=00000100", imem_re, imem_addr);
        end
        auto_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_redirect_ack_pop();
        test_illegal();
        test_wrap();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
